// File: rtl/hazard_stall_unit_if.sv
// rtl/hazard_stall_unit_if.sv - ID/EX hazard signals between pipeline (master) and hazard unit (slave)
interface hazard_stall_unit_if;
  logic       MemRead_ex;
  logic [4:0] writeReg_ex;
  logic [4:0] Rs_id;
  logic [4:0] Rt_id;
  logic       UseRs_id;
  logic       UseRt_id;
  logic       MduStart_id;
  logic       MduRead_id;
  logic       BranchTaken_ex;
  logic       PCWrite;
  logic       IFIDWrite;
  logic       IFIDFlush;
  logic       IDEXBubble;
  logic       MduBusy;

  modport master (
    output MemRead_ex, writeReg_ex, Rs_id, Rt_id, UseRs_id, UseRt_id,
           MduStart_id, MduRead_id, BranchTaken_ex,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MduBusy
  );

  modport slave (
    input  MemRead_ex, writeReg_ex, Rs_id, Rt_id, UseRs_id, UseRt_id,
           MduStart_id, MduRead_id, BranchTaken_ex,
    output PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MduBusy
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - decode-stage load-use/MDU stall and branch flush control
// Optional statistics counters enabled by defining HAZARD_STATS_EN.
module hazard_stall_unit #(
  parameter int MDU_LATENCY = 32,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_stall_unit_if.slave hz,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [CNT_W-1:0]   flush_count
);
  typedef enum logic {IDLE, BUSY} mduState_t;

  localparam logic [7:0] LAT_M1 = 8'(MDU_LATENCY - 1);

  mduState_t  state;
  logic [7:0] cnt;
  logic       mduBusy;
  logic       loadUse;
  logic       mduHazard;
  logic       stall;

  assign mduBusy = (state == BUSY);

  assign loadUse = hz.MemRead_ex && (hz.writeReg_ex != 5'd0) &&
                   ((hz.UseRs_id && (hz.Rs_id == hz.writeReg_ex)) ||
                    (hz.UseRt_id && (hz.Rt_id == hz.writeReg_ex)));
  assign mduHazard = mduBusy && (hz.MduStart_id || hz.MduRead_id);
  // A taken branch discards the ID instruction, so there is nothing left to stall.
  assign stall     = (loadUse || mduHazard) && !hz.BranchTaken_ex;

  assign hz.PCWrite    = !stall;
  assign hz.IFIDWrite  = !stall;
  assign hz.IDEXBubble = stall || hz.BranchTaken_ex;
  assign hz.IFIDFlush  = hz.BranchTaken_ex;
  assign hz.MduBusy    = mduBusy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hz.MduStart_id && !stall && !hz.BranchTaken_ex) begin
            cnt   <= LAT_M1;
            state <= BUSY;
          end
        end
        BUSY: begin
          // Branches never abort here: the issued MDU op is already committed.
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
          else             state <= IDLE;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + 1'b1;
      if (hz.BranchTaken_ex && (flush_count != {CNT_W{1'b1}}))
        flush_count <= flush_count + 1'b1;
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - self-checking bench for hazard_stall_unit
module tb_hazard_stall_unit;
  localparam int LAT   = 4;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;
`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_stall_unit_if hz();

  hazard_stall_unit #(.MDU_LATENCY(LAT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hz           (hz.slave),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  // Reference model: remaining busy cycles plus saturating event counts.
  int busyLeft = 0;
  int mStallCnt = 0;
  int mFlushCnt = 0;

  function automatic bit mStall();
    bit lu;
    bit md;
    lu = hz.MemRead_ex && (hz.writeReg_ex != 0) &&
         ((hz.UseRs_id && hz.Rs_id == hz.writeReg_ex) ||
          (hz.UseRt_id && hz.Rt_id == hz.writeReg_ex));
    md = (busyLeft > 0) && (hz.MduStart_id || hz.MduRead_id);
    return (lu || md) && !hz.BranchTaken_ex;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busyLeft  = 0;
      mStallCnt = 0;
      mFlushCnt = 0;
    end else begin
      bit st;
      st = mStall();
      if (st && mStallCnt < SAT) mStallCnt++;
      if (hz.BranchTaken_ex && mFlushCnt < SAT) mFlushCnt++;
      if (busyLeft > 0) busyLeft--;
      else if (hz.MduStart_id && !st && !hz.BranchTaken_ex) busyLeft = LAT;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkModel(input string tag);
    bit st;
    st = mStall();
    check({tag, ".PCWrite"},    int'(hz.PCWrite),    int'(!st));
    check({tag, ".IFIDWrite"},  int'(hz.IFIDWrite),  int'(!st));
    check({tag, ".IDEXBubble"}, int'(hz.IDEXBubble), int'(st || hz.BranchTaken_ex));
    check({tag, ".IFIDFlush"},  int'(hz.IFIDFlush),  int'(hz.BranchTaken_ex));
    check({tag, ".MduBusy"},    int'(hz.MduBusy),    int'(busyLeft > 0));
    check({tag, ".stall_cycles"}, int'(stall_cycles), STATS ? mStallCnt : 0);
    check({tag, ".flush_count"},  int'(flush_count),  STATS ? mFlushCnt : 0);
  endtask

  task automatic setIn(input bit mr, input int wr, input int rs, input int rt,
                       input bit urs, input bit urt, input bit st, input bit rd, input bit br);
    hz.MemRead_ex     = mr;
    hz.writeReg_ex    = 5'(wr);
    hz.Rs_id          = 5'(rs);
    hz.Rt_id          = 5'(rt);
    hz.UseRs_id       = urs;
    hz.UseRt_id       = urt;
    hz.MduStart_id    = st;
    hz.MduRead_id     = rd;
    hz.BranchTaken_ex = br;
  endtask

  task automatic doReset();
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    string name;
    bit mr; int wr; int rs; int rt; bit urs; bit urt; bit br;
    bit expPc; bit expBub; bit expFl;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{"lw_rs_hit",     1, 8, 8, 0, 1, 0, 0, 0, 1, 0};
    vecs[1] = '{"lw_r0",         1, 0, 0, 0, 1, 1, 0, 1, 0, 0};
    vecs[2] = '{"rt_unused",     1, 8, 0, 8, 0, 0, 0, 1, 0, 0};
    vecs[3] = '{"lw_rt_hit",     1, 8, 0, 8, 0, 1, 0, 0, 1, 0};
    vecs[4] = '{"no_load",       0, 8, 8, 8, 1, 1, 0, 1, 0, 0};
    vecs[5] = '{"lu_and_branch", 1, 8, 8, 0, 1, 0, 1, 1, 1, 1};
    vecs[6] = '{"branch_only",   0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    vecs[7] = '{"lw_r31_rt",     1, 31, 30, 31, 1, 1, 0, 0, 1, 0};
    vecs[8] = '{"idle",          0, 0, 0, 0, 0, 0, 0, 1, 0, 0};

    // Reset state
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("rst.MduBusy", int'(hz.MduBusy), 0);
    check("rst.PCWrite", int'(hz.PCWrite), 1);
    check("rst.stall_cycles", int'(stall_cycles), 0);
    check("rst.flush_count", int'(flush_count), 0);
    doReset();

    // Combinational vectors with the MDU idle
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      setIn(vecs[i].mr, vecs[i].wr, vecs[i].rs, vecs[i].rt, vecs[i].urs, vecs[i].urt, 0, 0, vecs[i].br);
      @(negedge clk);
      check({vecs[i].name, ".PCWrite"},    int'(hz.PCWrite),    int'(vecs[i].expPc));
      check({vecs[i].name, ".IFIDWrite"},  int'(hz.IFIDWrite),  int'(vecs[i].expPc));
      check({vecs[i].name, ".IDEXBubble"}, int'(hz.IDEXBubble), int'(vecs[i].expBub));
      check({vecs[i].name, ".IFIDFlush"},  int'(hz.IFIDFlush),  int'(vecs[i].expFl));
    end

    // mult at cycle 0, mflo waiting in ID from cycle 1
    doReset();
    @(posedge clk); #1;
    setIn(0, 0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    check("mdu.c0.MduBusy", int'(hz.MduBusy), 0);
    check("mdu.c0.PCWrite", int'(hz.PCWrite), 1);
    @(posedge clk); #1;
    setIn(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      check($sformatf("mdu.c%0d.MduBusy", c), int'(hz.MduBusy), 1);
      check($sformatf("mdu.c%0d.PCWrite", c), int'(hz.PCWrite), 0);
      if (c < LAT) @(posedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    check("mdu.c5.MduBusy", int'(hz.MduBusy), 0);
    check("mdu.c5.PCWrite", int'(hz.PCWrite), 1);

    // Load-use + branch + MduStart together: flush wins, no issue
    doReset();
    @(posedge clk); #1;
    setIn(1, 8, 8, 0, 1, 0, 1, 0, 1);
    @(negedge clk);
    check("flush.IFIDFlush",  int'(hz.IFIDFlush),  1);
    check("flush.IDEXBubble", int'(hz.IDEXBubble), 1);
    check("flush.PCWrite",    int'(hz.PCWrite),    1);
    @(posedge clk); #1;
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("flush.MduBusy", int'(hz.MduBusy), 0);

    // Asynchronous reset while BUSY with cnt=2
    doReset();
    @(posedge clk); #1;
    setIn(0, 0, 0, 0, 0, 0, 1, 0, 0);
    @(posedge clk); #1;
    setIn(0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(posedge clk); #1;
    check("arst.pre.MduBusy", int'(hz.MduBusy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst.MduBusy", int'(hz.MduBusy), 0);
    check("arst.PCWrite", int'(hz.PCWrite), 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("arst.post.PCWrite", int'(hz.PCWrite), 1);
    check("arst.post.MduBusy", int'(hz.MduBusy), 0);

    // 20 load-use stall cycles then 3 flushes: counters saturate at 15
    doReset();
    setIn(1, 8, 8, 0, 1, 0, 0, 0, 0);
    repeat (20) @(posedge clk);
    #1 setIn(0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) @(posedge clk);
    #1 setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("stats.stall_cycles", int'(stall_cycles), STATS ? 15 : 0);
    check("stats.flush_count",  int'(flush_count),  STATS ? 3 : 0);

    // Randomized traffic against the model
    doReset();
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      setIn($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 7) == 0);
      @(negedge clk);
      checkModel($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

- Decode-stage hazard controller for the 5-stage MIPS pipeline.
- Sits upstream of the EX-stage forwarding logic, alongside the ID stage.
- Handles the hazards forwarding cannot cover:
  - Load-use: freezes PC/IF-ID and injects an ID/EX bubble.
  - Multiply/divide structural hazard: tracks a multi-cycle MDU with a busy counter.
  - Taken branch/jump resolved in EX: flushes the younger instructions.

## Interface

Parameters:
- MDU_LATENCY, 32: cycles from an accepted MDU issue until HI/LO are valid; legal range 1..255.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- MemRead_ex  in  1  instruction in EX is a load.
- writeReg_ex  in  5  destination register of the instruction in EX.
- Rs_id, Rt_id  in  5 each  source registers of the instruction in ID.
- UseRs_id, UseRt_id  in  1 each  the ID instruction actually reads Rs / Rt.
- MduStart_id  in  1  ID instruction is mult/multu/div/divu.
- MduRead_id  in  1  ID instruction is mfhi/mflo.
- BranchTaken_ex  in  1  branch/jump in EX is taken; PC mux selects the target.
- PCWrite  out  1  PC register enable.
- IFIDWrite  out  1  IF/ID register enable.
- IFIDFlush  out  1  zero the IF/ID register on the next edge.
- IDEXBubble  out  1  zero ID/EX control bits on the next edge.
- MduBusy  out  1  MDU result pending.
- stall_cycles  out  CNT_W  count of cycles with PCWrite=0.
- flush_count  out  CNT_W  count of taken-branch flushes.

## Operation

Hazard terms:
- load_use = MemRead_ex & (writeReg_ex != 0) & ((UseRs_id & Rs_id == writeReg_ex) | (UseRt_id & Rt_id == writeReg_ex)).
- mdu_hazard = MduBusy & (MduStart_id | MduRead_id).
- stall = (load_use | mdu_hazard) & !BranchTaken_ex.

Outputs (combinational from inputs and registered state):
- PCWrite = IFIDWrite = !stall.
- IDEXBubble = stall | BranchTaken_ex.
- IFIDFlush = BranchTaken_ex.

Priority:
- Flush beats stall; the stalled ID instruction is discarded.
- A load-use stall needs no state: the bubble clears MemRead_ex the next cycle, so it lasts exactly 1 cycle.

MDU state machine, states IDLE and BUSY; down-counter cnt is 8 bits:
- IDLE: when MduStart_id & !stall & !BranchTaken_ex, load cnt = MDU_LATENCY-1 and go to BUSY.
- BUSY: MduBusy=1.
  - cnt != 0: decrement.
  - cnt == 0: return to IDLE at the edge.
- A new start arriving in BUSY is stalled, never queued.
- BranchTaken_ex does not abort BUSY; the issued MDU op is architecturally committed.
- MduBusy = (state == BUSY).

## Timing

- Reset (rst_n=0, asynchronous): state=IDLE, cnt=0, MduBusy=0, stall_cycles=0, flush_count=0.
  - PCWrite/IFIDWrite/IDEXBubble/IFIDFlush then follow the combinational equations with MduBusy=0.
- Reset mid-BUSY: returns to IDLE immediately; a pending mfhi proceeds.
- MduBusy rises the cycle after accepted issue and stays high exactly MDU_LATENCY cycles.
- mfhi in ID during the last BUSY cycle is stalled once, then proceeds.
- Load-use stall is 1 cycle. Back-to-back dependent loads give 1 stall each.
- No output is registered; all hazard outputs settle within the issuing cycle.

## Configuration

- HAZARD_STATS_EN defined:
  - stall_cycles increments every cycle PCWrite=0.
  - flush_count increments every cycle BranchTaken_ex=1.
  - Both saturate at all-ones and reset to 0.
- HAZARD_STATS_EN undefined: both ports remain and are tied to 0; no counter flops.

## Test plan

- lw $t0 in EX (MemRead_ex=1, writeReg_ex=8), add in ID with Rs_id=8, UseRs_id=1 -> one cycle PCWrite=0, IFIDWrite=0, IDEXBubble=1; next cycle all normal.
- Same case with writeReg_ex=0, or Rt_id=8 with UseRt_id=0 -> no stall.
- MDU_LATENCY=4: mult issues at cycle 0, mflo in ID from cycle 1 -> MduBusy=1 cycles 1-4; PCWrite=0 cycles 1-4; mflo advances at cycle 5.
- Load-use hazard and BranchTaken_ex=1 in the same cycle -> IFIDFlush=1, IDEXBubble=1, PCWrite=1, no stall; an MduStart_id in that cycle is not accepted, MduBusy stays 0.
- rst_n pulled low mid-BUSY (cnt=2) -> MduBusy=0 without a clock edge; after release, mfhi in ID passes with PCWrite=1.
- With HAZARD_STATS_EN, CNT_W=4, 20 stall cycles -> stall_cycles holds at 15. Without the macro -> stall_cycles reads 0.
